fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single enqueue port of one SyncFIFO among NREQ producers using
//  round-robin arbitration with bounded bursts. Each producer has a
//  valid/ready interface. Each beat is written into the FIFO tagged with its
//  source ID as {id, data}, so the consumer can demultiplex on the read side.
//  Sits directly in front of the FIFO write side, in the FIFO's write clock domain.
// PARAMETERS
//  NREQ   4   number of requesters (>=1)
//  DSIZE  11  payload width per requester
//  BURST  4   max beats per grant before forced re-arbitration (>=1)
//  IDW    localparam = max(1,$clog2(NREQ)); tag width
// PORTS
//  clk          in   1            write-domain clock, all logic posedge
//  rst          in   1            synchronous, active-high reset
//  req_valid    in   NREQ         per-requester beat valid
//  req_data     in   NREQ*DSIZE   payloads; requester i at [i*DSIZE +: DSIZE]
//  req_ready    out  NREQ         per-requester accept; one-hot or zero
//  fifo_enq     out  1            FIFO enqueue strobe (to sENQ)
//  fifo_data    out  IDW+DSIZE    {grant_id, payload} (to sD_IN)
//  fifo_full_n  in   1            FIFO not-full (from sFULL_N)
//  grant_id     out  IDW          currently granted requester
//  grant_active out  1            high while in GRANT state
// BEHAVIOUR
//  - Reset (rst high at posedge): state=IDLE, last=NREQ-1, beat_cnt=0,
//    grant_id=0. While rst is high, req_ready=0, fifo_enq=0, and grant_active=0,
//    regardless of state.
//  - Transfer rule: beat i moves when req_valid[i] && req_ready[i]. Then
//    fifo_enq=1 in the same cycle. A requester holds its data stable and keeps
//    valid high until the beat is accepted.
//  - IDLE: all req_ready=0, fifo_enq=0. If any req_valid, pick the first set bit
//    searching from (last+1) mod NREQ upward with wrap. Register grant_id and
//    go to GRANT next cycle with beat_cnt=0. This is one cycle of arbitration
//    latency. Otherwise stay in IDLE.
//  - GRANT (g=grant_id): req_ready[g]=fifo_full_n (combinational), all others
//    0. fifo_enq=req_valid[g]&&fifo_full_n. fifo_data={g, req_data[g]}.
//    * On an enq with beat_cnt==BURST-1: last<=g, go to IDLE.
//    * Else on an enq: beat_cnt<=beat_cnt+1.
//    * If req_valid[g]==0: no enq, last<=g, go to IDLE (early release).
//    * If req_valid[g]==1 and fifo_full_n==0: stall. Hold state and beat_cnt,
//      with no timeout.
//  - After any release there is always one IDLE bubble cycle, so
//    back-to-back grants are 1 cycle apart.
//  - Fairness: a requester that was just released has lowest priority at the
//    next arbitration. Worst-case wait is (NREQ-1)*(BURST+1) cycles plus any
//    cycles spent with the FIFO full.
//  - beat_cnt width is clog2(BURST)+1, and beat_cnt never exceeds BURST-1.
//  - NREQ=1: tag is 1 bit and always 0, and the requester is re-granted after
//    every bubble. BURST=1: every grant moves exactly one beat.
//  - Reset mid-burst: the partial burst is abandoned with no enq in the reset
//    cycle. The next grant goes to requester 0 if it is valid.
//  - Requests to non-granted requesters never change FIFO contents.
// TESTING
//  1 Reset, then only req0 valid with data 0x001..0x006, FIFO empty ->
//    0x001..0x004 enqueued as tag 0 on consecutive cycles. Then 1 bubble, and
//    0x005,0x006 follow after re-grant.
//  2 All 4 requesters valid, streaming -> grant order is 0,1,2,3,0. Each grant
//    moves 4 beats. grant_id sequence is checked, and the FIFO tag/data order
//    matches a per-source scoreboard.
//  3 Granted req2 with fifo_full_n=0 for 5 cycles mid-burst -> req_ready[2]=0
//    and fifo_enq=0 for those 5 cycles. beat_cnt is held, and the burst then
//    resumes with the remaining beats and no loss or duplication.
//  4 Granted req1 drops valid after 2 beats -> release. req1 gets lowest
//    priority, so req2 wins the next arbitration if it is valid.
//  5 rst asserted in the 3rd beat cycle of a burst -> fifo_enq=0 in that
//    cycle. After reset, state=IDLE and the first grant goes to requester 0.
//  6 Random valid/full for 10k cycles against the SyncFIFO with DSIZE=11.
//    Check that req_ready is one-hot or zero, that each producer's order is
//    preserved, that no beat is lost, and that the per-requester starvation
//    bound is never exceeded.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Producer and FIFO write-side bundle for fifo_write_arbiter.
// master drives requests and FIFO status; slave is the arbiter.
interface fifo_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 11,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_enq;
  logic [IDW+DSIZE-1:0]  fifo_data;
  logic                  fifo_full_n;

  modport master (
    output req_valid,
    output req_data,
    output fifo_full_n,
    input  req_ready,
    input  fifo_enq,
    input  fifo_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  fifo_full_n,
    output req_ready,
    output fifo_enq,
    output fifo_data
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port among NREQ
// producers, with bounded bursts and {id, data} tagging.
module fifo_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 11,
  parameter int BURST = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  fifo_write_arbiter_if.slave bus,
  output logic [IDW-1:0]   grant_id,
  output logic             grant_active
);

  localparam int CW = $clog2(BURST) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   last;
  logic [CW-1:0]    beat_cnt;

  logic [DSIZE-1:0] data_arr [NREQ];
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   idx;
  logic             any_valid;
  logic             g_valid;
  logic             in_grant;
  logic             last_beat;
  logic             full_n;

  function automatic logic [IDW-1:0] rr_idx(
    input logic [IDW-1:0] base,
    input int             k
  );
    int s;
    s = (int'(base) + k) % NREQ;
    return s[IDW-1:0];
  endfunction

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr[gi] = bus.req_data[gi*DSIZE +: DSIZE];
  end

  assign full_n    = bus.fifo_full_n;
  assign g_valid   = bus.req_valid[grant_id];
  assign in_grant  = (state == ST_GRANT) && !rst;
  assign last_beat = (beat_cnt == CW'(BURST - 1));

  // Search for the next valid requester, starting just after `last`.
  always_comb begin
    pick      = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = rr_idx(last, k);
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        pick      = idx;
      end
    end
  end

  // Only the granted requester sees ready, gated by FIFO space.
  always_comb begin
    bus.req_ready = '0;
    if (in_grant && full_n) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  assign bus.fifo_enq  = in_grant && g_valid && full_n;
  assign bus.fifo_data = {grant_id, data_arr[grant_id]};
  assign grant_active  = in_grant;

  // Arbitration state: IDLE picks, GRANT streams up to BURST beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= IDW'(NREQ - 1);
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          unique case (1'b1)
            !g_valid: begin
              last     <= grant_id;
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end
            g_valid && full_n && last_beat: begin
              last     <= grant_id;
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end
            g_valid && full_n && !last_beat: begin
              beat_cnt <= beat_cnt + CW'(1);
            end
            default: begin
            end
          endcase
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized bench for fifo_write_arbiter with a
// behavioural producer/FIFO/scoreboard model.
module tb_fifo_write_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 11;
  localparam int BURST = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;
  localparam int BOUND = (NREQ - 1) * (BURST + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IDW-1:0] grant_id;
  logic grant_active;

  fifo_write_arbiter_if #(
    .NREQ(NREQ), .DSIZE(DSIZE), .IDW(IDW)
  ) bus ();

  fifo_write_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant_id(grant_id),
    .grant_active(grant_active)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DSIZE-1:0]     src_q [NREQ][$];
  logic [DSIZE-1:0]     exp_q [NREQ][$];
  logic [IDW+DSIZE-1:0] fifo_q [$];
  logic [DSIZE-1:0]     seq [NREQ];
  int gq [$];
  int gb [$];
  int egq [$];
  int egb [$];
  int wt [NREQ];

  bit use_fifo = 1'b0;
  bit stall = 1'b0;
  bit prev_active = 1'b0;

  logic                 last_enq;
  logic                 last_active;
  logic [IDW-1:0]       last_gid;
  logic [NREQ-1:0]      last_ready;
  logic [IDW+DSIZE-1:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = src_q[i].size() > 0;
      bus.req_data[i*DSIZE +: DSIZE] =
        (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    bus.fifo_full_n = use_fifo ? (fifo_q.size() < DEPTH) : !stall;
  endtask

  task automatic gen_v(input int i, input logic [DSIZE-1:0] v);
    src_q[i].push_back(v);
    exp_q[i].push_back(v);
  endtask

  task automatic pop_check();
    logic [IDW+DSIZE-1:0] w;
    int t;
    w = fifo_q.pop_front();
    t = int'(w[DSIZE +: IDW]);
    if (exp_q[t].size() == 0) begin
      chk("sb_extra_beat", 32'(exp_q[t].size()), 1);
    end else begin
      chk("sb_order", 32'(w[DSIZE-1:0]), 32'(exp_q[t].pop_front()));
    end
  endtask

  task automatic cycle();
    logic [NREQ-1:0] acc;
    logic [IDW+DSIZE-1:0] w;
    int t;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    last_enq    = bus.fifo_enq;
    last_active = grant_active;
    last_gid    = grant_id;
    last_ready  = bus.req_ready;
    last_data   = bus.fifo_data;
    chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
    chk("enq_vs_xfer", 32'(bus.fifo_enq), 32'(|acc));
    if (rst) begin
      chk("rst_quiet",
          32'({bus.req_ready, bus.fifo_enq, grant_active}), 0);
    end
    if (bus.fifo_enq) begin
      w = bus.fifo_data;
      t = int'(w[DSIZE +: IDW]);
      chk("tag_vs_ready", 32'(acc[t]), 1);
      if (src_q[t].size() > 0) begin
        chk("data_vs_head", 32'(w[DSIZE-1:0]), 32'(src_q[t][0]));
      end
      fifo_q.push_back(w);
    end
    if (grant_active && !prev_active) begin
      gq.push_back(int'(grant_id));
      gb.push_back(0);
    end
    if (bus.fifo_enq && gb.size() > 0) begin
      gb[gb.size()-1] = gb[gb.size()-1] + 1;
    end
    prev_active = grant_active;
    for (int i = 0; i < NREQ; i++) begin
      if (rst || !bus.req_valid[i] ||
          (grant_active && int'(grant_id) == i)) begin
        wt[i] = 0;
      end else if (bus.fifo_full_n) begin
        wt[i]++;
        chk("starve_bound", 32'(wt[i] <= BOUND), 1);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    if (use_fifo) begin
      if (fifo_q.size() > 0 && $urandom_range(0, 1) == 1) pop_check();
    end else begin
      while (fifo_q.size() > 0) pop_check();
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    run(2);
    chk("rst_grant_id", 32'(last_gid), 0);
    rst = 1'b0;
    gq.delete();
    gb.delete();
    prev_active = 1'b0;
  endtask

  task automatic check_grants(input string tag);
    chk({tag, "_ngrants"}, 32'(gq.size()), 32'(egq.size()));
    for (int i = 0; i < egq.size(); i++) begin
      if (i < gq.size()) begin
        chk({tag, "_gid"}, 32'(gq[i]), 32'(egq[i]));
        chk({tag, "_beats"}, 32'(gb[i]), 32'(egb[i]));
      end
    end
  endtask

  task automatic check_empty(input string tag);
    for (int i = 0; i < NREQ; i++) begin
      chk({tag, "_lost"}, 32'(exp_q[i].size()), 0);
    end
  endtask

  function automatic bit busy();
    bit b;
    b = fifo_q.size() > 0;
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) b = 1'b1;
    end
    return b;
  endfunction

  int ex1 [10] = '{-1, 1, 2, 3, 4, -1, 5, 6, -1, -1};

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.fifo_full_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = '0;
      wt[i] = 0;
    end

    // 1: single requester, burst of 4, bubble, then the rest
    do_reset();
    for (int v = 1; v <= 6; v++) gen_v(0, 11'(v));
    drive();
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("t1_enq", 32'(last_enq), 32'(ex1[c] >= 0));
      if (ex1[c] >= 0) chk("t1_data", 32'(last_data), 32'(ex1[c]));
    end
    egq = '{0, 0};
    egb = '{4, 2};
    check_grants("t1");
    check_empty("t1");

    // 2: all four streaming, round-robin order with full bursts
    do_reset();
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NREQ; i++) gen_v(i, 11'(i * 64 + b));
    end
    drive();
    run(50);
    egq = '{0, 1, 2, 3, 0, 1, 2, 3};
    egb = '{4, 4, 4, 4, 4, 4, 4, 4};
    check_grants("t2");
    check_empty("t2");

    // 3: FIFO full for 5 cycles in the middle of req2's burst
    do_reset();
    for (int v = 0; v < 6; v++) gen_v(2, 11'(v + 32));
    drive();
    run(3);
    stall = 1'b1;
    drive();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("t3_ready2", 32'(last_ready[2]), 0);
      chk("t3_enq", 32'(last_enq), 0);
      chk("t3_active", 32'(last_active), 1);
    end
    stall = 1'b0;
    drive();
    run(12);
    egq = '{2, 2};
    egb = '{4, 2};
    check_grants("t3");
    check_empty("t3");

    // 4: req1 releases early and loses the next arbitration
    do_reset();
    gen_v(1, 11'h10);
    gen_v(1, 11'h11);
    for (int v = 0; v < 3; v++) gen_v(2, 11'(v + 11'h20));
    drive();
    run(4);
    gen_v(0, 11'h30);
    gen_v(1, 11'h12);
    gen_v(1, 11'h13);
    drive();
    run(20);
    egq = '{1, 2, 0, 1};
    egb = '{2, 3, 1, 2};
    check_grants("t4");
    check_empty("t4");

    // 5: reset in the 3rd beat cycle of a burst
    do_reset();
    for (int v = 0; v < 8; v++) gen_v(0, 11'(v + 11'h100));
    drive();
    run(3);
    rst = 1'b1;
    gen_v(3, 11'h1f0);
    gen_v(3, 11'h1f1);
    drive();
    cycle();
    chk("t5_rst_enq", 32'(last_enq), 0);
    chk("t5_rst_ready", 32'(last_ready), 0);
    chk("t5_rst_active", 32'(last_active), 0);
    rst = 1'b0;
    cycle();
    chk("t5_idle_active", 32'(last_active), 0);
    chk("t5_idle_enq", 32'(last_enq), 0);
    cycle();
    chk("t5_regrant_active", 32'(last_active), 1);
    chk("t5_regrant_id", 32'(last_gid), 0);
    chk("t5_regrant_data", 32'(last_data), 32'h102);
    run(40);
    check_empty("t5");

    // 6: random producers against a small FIFO with random drain
    do_reset();
    use_fifo = 1'b1;
    drive();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          gen_v(i, seq[i]);
          seq[i] = seq[i] + 11'd1;
        end
      end
      drive();
      cycle();
    end
    for (int n = 0; n < 3000 && busy(); n++) cycle();
    chk("t6_drained", 32'(busy()), 0);
    check_empty("t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
